// File: rtl/adder16_seq.sv
// adder16_seq: 16-bit add/subtract sequenced over a single 4-bit nibble slice, LSB nibble first.
// Ports: clk, rst_n (sync, active-low), start/op_a/op_b/sub (request), busy/done/result/cout/ovf (registered).
// Macro ADDER16_SUB_EN: when defined, sub selects A-B; when undefined, sub is ignored and every op is A+B.
module adder16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q;
  logic [1:0]  idx_q;
  logic [15:0] a_q, b_q, result_q;
  logic        carry_q, busy_q, done_q, cout_q, ovf_q;
  logic        sub_en;
  logic [3:0]  base;
  logic [4:0]  nib_d;
`ifdef ADDER16_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0 & sub;
`endif
  assign base  = {idx_q, 2'b00};
  assign nib_d = {1'b0, a_q[base +: 4]} + {1'b0, b_q[base +: 4]} + {4'b0, carry_q};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'd0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q     <= op_a;
          b_q     <= sub_en ? ~op_b : op_b;
          carry_q <= sub_en;
          idx_q   <= 2'd0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          result_q[base +: 4] <= nib_d[3:0];
          carry_q             <= nib_d[4];
          idx_q               <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cout_q  <= nib_d[4];
            ovf_q   <= (a_q[15] == b_q[15]) && (nib_d[3] != a_q[15]);
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_adder16_seq.sv
// tb_adder16_seq: directed scoreboard bench for adder16_seq; expectations follow ADDER16_SUB_EN.
module tb_adder16_seq;
`ifdef ADDER16_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;
  logic        sub = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] result;
  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
    string       name;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  adder16_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .sub(sub),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (result 0x%0h)", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_result"}, {16'd0, result}, {16'd0, e.r});
        chk({e.name, "_cout"}, {31'd0, cout}, {31'd0, e.c});
        chk({e.name, "_ovf"}, {31'd0, ovf}, {31'd0, e.o});
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      seen = done;
    end
    chk({name, "_latency"}, n, 4);
    @(posedge clk);
    #1;
    chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] r, input logic c, input logic o, input string name);
    @(negedge clk);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    exp_q.push_back('{r: r, c: c, o: o, name: name});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, cout, ovf, result}, 20'd0);
    rst_n = 1'b1;
    // abort an operation mid-CALC with a two-cycle reset
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midcalc_reset", {busy, done, cout, ovf, result}, 20'd0);
    rst_n = 1'b1;
    run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, "ripple");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "sovf");
    run_op(16'h0003, 16'h0005, 1'b1, SUB_EN ? 16'hFFFE : 16'h0008, 1'b0, 1'b0, "sub3m5");
    run_op(16'h8000, 16'h0001, 1'b1, SUB_EN ? 16'h7FFF : 16'h8001, SUB_EN, SUB_EN, "sub8000m1");
    run_op(16'h5A5A, 16'hA5A5, 1'b0, 16'hFFFF, 1'b0, 1'b0, "alt");
    // starts at k+2 and k+5 are ignored, operands change after accept, start at k+6 accepted
    @(negedge clk);
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h1111;
    sub   = 1'b0;
    exp_q.push_back('{r: 16'h2345, c: 1'b0, o: 1'b0, name: "busy_first"});
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'hAAAA;
    op_b  = 16'h5555;
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = 16'hFFFF;
    op_b  = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_done_k4", {31'd0, done}, 32'd1);
    start = 1'b1;
    op_a  = 16'h0100;
    op_b  = 16'h0200;
    @(posedge clk);
    #1;
    chk("busy_k5_ignored", {30'd0, busy, done}, 32'd0);
    exp_q.push_back('{r: 16'h0300, c: 1'b0, o: 1'b0, name: "accept_k6"});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_k6_busy", {31'd0, busy}, 32'd1);
    wait_done("accept_k6");
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
